// File: rtl/calc_sequencer_if.sv
// Keypad, ALU handshake and display signals of the calculator sequencer.
// master = the sequencer itself, slave = keypad/ALU/display environment.
interface calc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             dig_strobe;
    logic [3:0]       dig_code;
    logic             op_strobe;
    logic [1:0]       op_code;
    logic             ex_strobe;
    logic             reset_strobe;
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] display_value;
    logic             error;
    logic             busy;

    modport master (
        input  dig_strobe, dig_code, op_strobe, op_code, ex_strobe, reset_strobe,
        input  alu_done, alu_result, alu_err,
        output alu_start, alu_op, alu_a, alu_b,
        output display_value, error, busy
    );

    modport slave (
        output dig_strobe, dig_code, op_strobe, op_code, ex_strobe, reset_strobe,
        output alu_done, alu_result, alu_err,
        input  alu_start, alu_op, alu_a, alu_b,
        input  display_value, error, busy
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator controller: builds decimal operands, drives the ALU start/done handshake and the display.
// Define CALC_CHAIN_OP_EN to let an operator key in ENTER_B evaluate the pending operation (left-to-right chaining).
module calc_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    calc_sequencer_if.master  bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

    typedef enum logic [2:0] {
        ENTER_A,
        OP_SEL,
        ENTER_B,
        EXEC,
        SHOW,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
`ifdef CALC_CHAIN_OP_EN
    logic [1:0]       pend_q, pend_d;
    logic             chain_q, chain_d;
`endif

    logic             ex, op, dig;
    logic [WIDTH-1:0] dig_val, edit, appended;
    logic             can_add, leading0;

    always_ff @(posedge clk) begin
        if (rst || bus.reset_strobe) begin
            state_q  <= ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            count_q  <= '0;
            op_q     <= '0;
            disp_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
`ifdef CALC_CHAIN_OP_EN
            pend_q   <= '0;
            chain_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            count_q  <= count_d;
            op_q     <= op_d;
            disp_q   <= disp_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
`ifdef CALC_CHAIN_OP_EN
            pend_q   <= pend_d;
            chain_q  <= chain_d;
`endif
        end
    end

    // Strobe priority: ex > op > dig; an out-of-range digit code is treated as no key.
    assign ex       = bus.ex_strobe;
    assign op       = bus.op_strobe & ~ex;
    assign dig      = bus.dig_strobe & ~ex & ~op & (bus.dig_code <= 4'd9);
    assign dig_val  = {{(WIDTH-4){1'b0}}, bus.dig_code};
    assign edit     = (state_q == ENTER_B) ? b_q : a_q;
    assign appended = edit * TEN + dig_val;
    assign can_add  = count_q < CW'(MAX_DIGITS);
    assign leading0 = (edit == '0) && (bus.dig_code == 4'd0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        count_d  = count_q;
        op_d     = op_q;
        disp_d   = disp_q;
        err_d    = err_q;
        busy_d   = busy_q;
        start_d  = 1'b0;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
`ifdef CALC_CHAIN_OP_EN
        pend_d   = pend_q;
        chain_d  = chain_q;
`endif
        case (state_q)
            ENTER_A: begin
                if (op) begin
                    op_d    = bus.op_code;
                    state_d = OP_SEL;
                end else if (dig && can_add && !leading0) begin
                    a_d     = appended;
                    disp_d  = appended;
                    count_d = count_q + CW'(1);
                end
            end
            OP_SEL: begin
                if (op) begin
                    op_d = bus.op_code;
                end else if (dig) begin
                    b_d     = dig_val;
                    disp_d  = dig_val;
                    count_d = CW'(bus.dig_code != 4'd0);
                    state_d = ENTER_B;
                end
            end
            ENTER_B: begin
                if (ex) begin
                    alu_a_d  = a_q;
                    alu_b_d  = b_q;
                    alu_op_d = op_q;
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = EXEC;
`ifdef CALC_CHAIN_OP_EN
                    chain_d  = 1'b0;
                end else if (op) begin
                    alu_a_d  = a_q;
                    alu_b_d  = b_q;
                    alu_op_d = op_q;
                    start_d  = 1'b1;
                    busy_d   = 1'b1;
                    pend_d   = bus.op_code;
                    chain_d  = 1'b1;
                    state_d  = EXEC;
`endif
                end else if (dig && can_add && !leading0) begin
                    b_d     = appended;
                    disp_d  = appended;
                    count_d = count_q + CW'(1);
                end
            end
            EXEC: begin
                if (bus.alu_done) begin
                    busy_d = 1'b0;
                    if (bus.alu_err) begin
                        disp_d  = '0;
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        a_d     = bus.alu_result;
                        disp_d  = bus.alu_result;
                        state_d = SHOW;
`ifdef CALC_CHAIN_OP_EN
                        if (chain_q) begin
                            op_d    = pend_q;
                            state_d = OP_SEL;
                        end
`endif
                    end
                end
            end
            SHOW: begin
                if (op) begin
                    op_d    = bus.op_code;
                    state_d = OP_SEL;
                end else if (dig) begin
                    a_d     = dig_val;
                    disp_d  = dig_val;
                    count_d = CW'(bus.dig_code != 4'd0);
                    state_d = ENTER_A;
                end
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: state_d = ENTER_A;
        endcase
    end

    assign bus.alu_start     = start_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.display_value = disp_q;
    assign bus.error         = err_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key table with hand-computed displays plus error/abort/priority sequences.
module tb_calc_sequencer;
    localparam int K_DIG = 0;
    localparam int K_OP  = 1;
    localparam int K_EX  = 2;
    localparam int K_CLR = 3;

    typedef struct {
        int          kind;
        int          code;
        logic [15:0] disp;
        bit          wt;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [1:0]  eop;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_start = 0;
    int   run     = 0;
    int   max_run = 0;
    int   alu_lat = 3;
    vec_t vt[$];

    calc_sequencer_if #(.WIDTH(16)) bus ();

    calc_sequencer #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ALU model: answers each alu_start after alu_lat cycles.
    initial begin
        logic signed [15:0] sa, sb;
        int ra;
        logic ovf;
        bus.alu_done   = 1'b0;
        bus.alu_err    = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            if (bus.alu_start === 1'b1) begin
                sa = bus.alu_a;
                sb = bus.alu_b;
                ovf = 1'b0;
                case (bus.alu_op)
                    2'd0: ra = int'(sa) + int'(sb);
                    2'd1: ra = int'(sa) - int'(sb);
                    2'd2: ra = int'(sa) * int'(sb);
                    default: begin
                        if (sb == 0) begin ra = 0; ovf = 1'b1; end
                        else ra = int'(sa) / int'(sb);
                    end
                endcase
                if (ra > 32767 || ra < -32768) ovf = 1'b1;
                repeat (alu_lat - 1) @(negedge clk);
                bus.alu_done   = 1'b1;
                bus.alu_err    = ovf;
                bus.alu_result = ovf ? 16'h0 : 16'(ra);
                @(negedge clk);
                bus.alu_done = 1'b0;
                bus.alu_err  = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.alu_start === 1'b1) begin
                n_start++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int k, input int c, input int d, input bit w = 1'b0,
                       input int ea = 0, input int eb = 0, input int eop = 0);
        vec_t v;
        v.kind = k;
        v.code = c;
        v.disp = 16'(d);
        v.wt   = w;
        v.ea   = 16'(ea);
        v.eb   = 16'(eb);
        v.eop  = 2'(eop);
        vt.push_back(v);
    endtask

    task automatic press(input int k, input int c);
        case (k)
            K_DIG:   begin bus.dig_strobe = 1'b1; bus.dig_code = 4'(c); end
            K_OP:    begin bus.op_strobe  = 1'b1; bus.op_code  = 2'(c); end
            K_EX:    bus.ex_strobe    = 1'b1;
            default: bus.reset_strobe = 1'b1;
        endcase
        @(negedge clk);
        bus.dig_strobe   = 1'b0;
        bus.op_strobe    = 1'b0;
        bus.ex_strobe    = 1'b0;
        bus.reset_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30; i++) begin
            if (bus.busy === 1'b0) break;
            @(negedge clk);
        end
        check({name, " busy_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int saved;
        bus.dig_strobe   = 1'b0;
        bus.dig_code     = '0;
        bus.op_strobe    = 1'b0;
        bus.op_code      = '0;
        bus.ex_strobe    = 1'b0;
        bus.reset_strobe = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset display", 32'(bus.display_value), 32'd0);
        check("reset error",   32'(bus.error),         32'd0);
        check("reset busy",    32'(bus.busy),          32'd0);
        check("reset start",   32'(bus.alu_start),     32'd0);
        check("reset alu_a",   32'(bus.alu_a),         32'd0);
        check("reset alu_b",   32'(bus.alu_b),         32'd0);
        check("reset alu_op",  32'(bus.alu_op),        32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 12 + 34, then 46 - 6, then fresh digit from SHOW
        add(K_CLR, 0, 0);
        add(K_DIG, 1, 1);  add(K_DIG, 2, 12); add(K_OP, 0, 12);
        add(K_DIG, 3, 3);  add(K_DIG, 4, 34); add(K_EX, 0, 46, 1, 12, 34, 0);
        add(K_OP, 1, 46);  add(K_DIG, 6, 6);  add(K_EX, 0, 40, 1, 46, 6, 1);
        add(K_DIG, 5, 5);
        // digit limit
        add(K_CLR, 0, 0);
        add(K_DIG, 1, 1); add(K_DIG, 2, 12); add(K_DIG, 3, 123);
        add(K_DIG, 4, 1234); add(K_DIG, 5, 1234);
        // leading zeros do not use up digit slots; code > 9 ignored
        add(K_CLR, 0, 0);
        add(K_DIG, 0, 0); add(K_DIG, 0, 0); add(K_DIG, 7, 7); add(K_DIG, 8, 78);
        add(K_DIG, 9, 789); add(K_DIG, 1, 7891); add(K_DIG, 2, 7891); add(K_DIG, 10, 7891);
        // 2 + 3 * 4
        add(K_CLR, 0, 0);
        add(K_DIG, 2, 2); add(K_OP, 0, 2); add(K_DIG, 3, 3);
`ifdef CALC_CHAIN_OP_EN
        add(K_OP, 2, 5, 1, 2, 3, 0);
        add(K_DIG, 4, 4);
        add(K_EX, 0, 20, 1, 5, 4, 2);
`else
        add(K_OP, 2, 3);
        add(K_DIG, 4, 34);
        add(K_EX, 0, 36, 1, 2, 34, 0);
`endif
        // negative result carried as A, then fresh positive A
        add(K_CLR, 0, 0);
        add(K_DIG, 3, 3); add(K_OP, 1, 3); add(K_DIG, 5, 5);
        add(K_EX, 0, -2, 1, 3, 5, 1);
        add(K_OP, 0, -2); add(K_DIG, 4, 4); add(K_EX, 0, 2, 1, -2, 4, 0);
        add(K_DIG, 7, 7);

        foreach (vt[i]) begin
            press(vt[i].kind, vt[i].code);
            if (vt[i].wt) begin
                check($sformatf("v%0d start", i),  32'(bus.alu_start), 32'd1);
                check($sformatf("v%0d busy", i),   32'(bus.busy),      32'd1);
                check($sformatf("v%0d alu_a", i),  32'(bus.alu_a),     32'(vt[i].ea));
                check($sformatf("v%0d alu_b", i),  32'(bus.alu_b),     32'(vt[i].eb));
                check($sformatf("v%0d alu_op", i), 32'(bus.alu_op),    32'(vt[i].eop));
                wait_idle($sformatf("v%0d", i));
            end
            check($sformatf("v%0d display", i), 32'(bus.display_value), 32'(vt[i].disp));
            check($sformatf("v%0d error", i),   32'(bus.error),         32'd0);
        end

        // 7 / 0 -> error state ignores everything but clear
        press(K_CLR, 0);
        press(K_DIG, 7); press(K_OP, 3); press(K_DIG, 0);
        press(K_EX, 0);
        wait_idle("div0");
        check("div0 error",   32'(bus.error),         32'd1);
        check("div0 display", 32'(bus.display_value), 32'd0);
        saved = n_start;
        press(K_DIG, 5); press(K_OP, 0); press(K_EX, 0);
        repeat (4) @(negedge clk);
        check("err hold error",   32'(bus.error),         32'd1);
        check("err hold display", 32'(bus.display_value), 32'd0);
        check("err hold busy",    32'(bus.busy),          32'd0);
        check("err no start",     32'(n_start),           32'(saved));
        press(K_CLR, 0);
        check("clear error",   32'(bus.error),         32'd0);
        check("clear display", 32'(bus.display_value), 32'd0);
        press(K_DIG, 3);
        check("after clear digit", 32'(bus.display_value), 32'd3);

        // 9 * 9 aborted by clear; late alu_done must be dropped
        press(K_CLR, 0);
        press(K_DIG, 9); press(K_OP, 2); press(K_DIG, 9);
        press(K_EX, 0);
        check("abort start", 32'(bus.alu_start), 32'd1);
        press(K_CLR, 0);
        repeat (6) @(negedge clk);
        check("abort display", 32'(bus.display_value), 32'd0);
        check("abort busy",    32'(bus.busy),          32'd0);
        check("abort error",   32'(bus.error),         32'd0);
        press(K_DIG, 4); press(K_DIG, 2);
        check("abort then digits", 32'(bus.display_value), 32'd42);

        // op and dig in one cycle: op wins, digit dropped
        press(K_CLR, 0);
        press(K_DIG, 5);
        bus.dig_strobe = 1'b1; bus.dig_code = 4'd8;
        bus.op_strobe  = 1'b1; bus.op_code  = 2'd0;
        @(negedge clk);
        bus.dig_strobe = 1'b0; bus.op_strobe = 1'b0;
        check("prio display", 32'(bus.display_value), 32'd5);
        press(K_DIG, 3);
        check("prio op taken", 32'(bus.display_value), 32'd3);
        // ex and dig together in ENTER_B: ex wins
        bus.dig_strobe = 1'b1; bus.dig_code = 4'd1;
        bus.ex_strobe  = 1'b1;
        @(negedge clk);
        bus.dig_strobe = 1'b0; bus.ex_strobe = 1'b0;
        check("prio ex alu_b", 32'(bus.alu_b), 32'd3);
        wait_idle("prio ex");
        check("prio ex result", 32'(bus.display_value), 32'd8);

        check("start pulse width", 32'(max_run), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central controller for the calculator. It consumes the decoded keypad strobes and codes (digit, operator, execute, clear) and builds two decimal operands in binary. It hands the operands and operator to the shared arithmetic unit over a start/done handshake and drives the value shown on the display. It sits between the keypad decoder and the ALU/display path.

Parameters:
WIDTH, 16, operand/result/display width in bits, two's complement
MAX_DIGITS, 4, maximum decimal digits per entered operand; 10^MAX_DIGITS - 1 must fit in WIDTH-1 bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
dig_strobe  input  1  one-cycle pulse, digit key pressed
dig_code  input  4  digit value 0-9, valid with dig_strobe
op_strobe  input  1  one-cycle pulse, operator key pressed
op_code  input  2  0=+, 1=-, 2=*, 3=/, valid with op_strobe
ex_strobe  input  1  one-cycle pulse, execute (=) key
reset_strobe  input  1  one-cycle pulse, clear key
alu_start  output  1  one-cycle request pulse to ALU
alu_op  output  2  operator for ALU, held from alu_start until alu_done
alu_a  output  WIDTH  left operand, held likewise
alu_b  output  WIDTH  right operand, held likewise
alu_done  input  1  one-cycle pulse, ALU result valid
alu_result  input  WIDTH  signed result, valid with alu_done
alu_err  input  1  ALU error (divide by zero, overflow), valid with alu_done
display_value  output  WIDTH  signed value to show
error  output  1  error indicator
busy  output  1  high while waiting on ALU

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset state (rst or reset_strobe), all registered:
  - state=ENTER_A
  - operands A=B=0, digit count=0, latched op=0
  - display_value=0, error=0, busy=0, alu_start=0
  - alu_a, alu_b and alu_op are 0.
- Strobe priority when several are high in one cycle: reset_strobe > ex_strobe > op_strobe > dig_strobe; lower-priority strobes are dropped.
- Latency: display_value and state update on the clock edge after the strobe cycle.
- Digit entry (ENTER_A on A, ENTER_B on B):
  - If count < MAX_DIGITS: operand = operand*10 + dig_code and count++. Arithmetic is in WIDTH bits and cannot overflow because of the MAX_DIGITS limit.
  - A leading zero (operand==0 and dig_code==0) does not increment count.
  - When count == MAX_DIGITS, the digit is ignored.
  - dig_code > 9 with dig_strobe is ignored.
  - display_value = the operand being edited.
- States:
  - ENTER_A:
    - dig: append to A.
    - op: latch op, go to OP_SEL.
    - ex: ignored.
  - OP_SEL:
    - op: replace the latched op.
    - dig: B = dig_code, count = (dig_code != 0), go to ENTER_B, display B.
    - ex: ignored.
  - ENTER_B:
    - dig: append to B.
    - ex: drive alu_a=A, alu_b=B, alu_op=latched op, pulse alu_start for exactly one cycle, busy=1, go to EXEC.
    - op: see the optional feature.
  - EXEC:
    - Every strobe except reset_strobe is ignored.
    - On alu_done with alu_err=0: A=alu_result, display A, busy=0, go to SHOW (or OP_SEL for a chained op).
    - On alu_done with alu_err=1: display 0, error=1, busy=0, go to ERR.
  - SHOW:
    - op: latch op, go to OP_SEL; the result is used as A.
    - dig: A=dig_code, count reset, go to ENTER_A.
    - ex: ignored.
  - ERR: every strobe except reset_strobe is ignored; error stays 1.
- alu_done is honoured only in EXEC. reset_strobe mid-EXEC returns to ENTER_A; the late alu_done from the aborted operation is dropped and not displayed.
- alu_done arriving in the same cycle as alu_start is not possible: the ALU latency is at least 1 cycle.
- Negative results are carried as A; further digit entry from SHOW starts a fresh, positive A.

Optional Feature:
Macro: CALC_CHAIN_OP_EN
- Defined: op_strobe in ENTER_B evaluates the pending operation.
  - It issues alu_start with A, B and the old op, stores the new op_code as pending, and goes to EXEC.
  - On success, A=result, the pending op becomes the latched op, and the state goes to OP_SEL with the result displayed.
  - The result is left-to-right evaluation with no precedence.
- Not defined: op_strobe in ENTER_B is ignored; B and the latched op are unchanged.

Test Plan:
- Keys 1,2,+,3,4,= with an ALU model of 3-cycle latency -> alu_start high for exactly 1 cycle with alu_a=12, alu_b=34, alu_op=0; busy=1 until done; display_value=46; state SHOW.
- Keys 1,2,3,4,5 -> display_value=1234 (fifth digit ignored); then 0,0 after a clear -> display stays 0 and count stays 0.
- Keys 7,/,0,= with the ALU returning alu_err=1 -> error=1, display_value=0; digits, op and = are ignored; reset_strobe -> error=0, display 0, ENTER_A.
- Keys 9,*,9,= then reset_strobe one cycle after alu_start, with alu_done arriving 2 cycles later -> display_value stays 0, busy=0, no transition to SHOW.
- After result 46: keys -,6,= -> alu_a=46, alu_b=6, alu_op=1, display 40. After result 40: key 5 -> display 5, ENTER_A.
- Keys 2,+,3,*,4,= -> with CALC_CHAIN_OP_EN: display 5 after *, final 20; without it: * ignored, B=34, final 36.
